// File: rtl/branch_pkg.sv
// Shared branch-resolution types: condition codes and 2-bit predictor counter encoding.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_BEQ    = 3'd0,
    BR_BNE    = 3'd1,
    BR_BLEZ   = 3'd2,
    BR_BGTZ   = 3'd3,
    BR_BLTZ   = 3'd4,
    BR_BGEZ   = 3'd5,
    BR_ALWAYS = 3'd6,
    BR_RSVD   = 3'd7
  } brOp_t;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT   = 2'b00;
  localparam cnt_t CNT_WNT   = 2'b01;
  localparam cnt_t CNT_WT    = 2'b10;
  localparam cnt_t CNT_ST    = 2'b11;
  localparam cnt_t PHT_RESET = CNT_WNT;

  // Saturating step toward the resolved direction.
  function automatic cnt_t cntNext(input cnt_t c, input logic tk);
    if (tk) return (c == CNT_ST) ? CNT_ST : cnt_t'(c + 2'd1);
    else    return (c == CNT_SNT) ? CNT_SNT : cnt_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/response handshake bundle between decode, the branch resolver and PC select.
interface branch_resolve_unit_if #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned IMM_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    pc;
  logic [IMM_W-1:0] imm;
  logic [DW-1:0]    rs_val;
  logic [DW-1:0]    rt_val;
  logic [2:0]       br_op;
  logic             pred_taken;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic [AW-1:0]    target;
  logic [AW-1:0]    next_pc;
  logic             mispredict;

  modport master (
    output in_valid, pc, imm, rs_val, rt_val, br_op, pred_taken, out_ready,
    input  in_ready, out_valid, taken, target, next_pc, mispredict
  );

  modport slave (
    input  in_valid, pc, imm, rs_val, rt_val, br_op, pred_taken, out_ready,
    output in_ready, out_valid, taken, target, next_pc, mispredict
  );
endinterface

// File: rtl/branch_pht.sv
// Pattern history table of 2-bit saturating counters: async read port, one sync update port.
module branch_pht
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rdIdx,
  output logic          rdTaken,
  input  logic          updEn,
  input  logic [IW-1:0] updIdx,
  input  logic          updTaken
);

  cnt_t cnt [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) cnt[i] <= PHT_RESET;
    end else if (updEn) begin
      cnt[updIdx] <= cntNext(cnt[updIdx], updTaken);
    end
  end

  // Reads see the pre-update value when colliding with an update.
  assign rdTaken = cnt[rdIdx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolver: target adder, condition evaluation, mispredict flag and PHT training.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned IMM_W     = 16,
  parameter int unsigned SHIFT     = 2,
  parameter int unsigned PHT_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus,
  input  logic                  flush,
  input  logic [AW-1:0]         lookup_pc,
  output logic                  lookup_taken
);

  localparam int unsigned IW = $clog2(PHT_DEPTH);

  logic          s1Valid, s1Taken, s1Pred;
  logic [AW-1:0] s1PcPlus4, s1Target;
  logic [IW-1:0] s1Idx;

  logic          s2Valid, s2Taken, s2Mis;
  logic [AW-1:0] s2Target, s2NextPc;
  logic [IW-1:0] s2Idx;

  logic          s2Adv, s1Adv, accept, condTaken;
  logic [AW-1:0] pcPlus4, brTarget, immExt;
  logic          unusedLookupBits;

  assign s2Adv  = !s2Valid || bus.out_ready;
  assign s1Adv  = !s1Valid || s2Adv;
  assign bus.in_ready = s1Adv && !flush;
  assign accept = bus.in_valid && bus.in_ready;

  // Target arithmetic wraps modulo 2^AW.
  assign immExt   = AW'($signed(bus.imm));
  assign pcPlus4  = bus.pc + AW'(4);
  assign brTarget = pcPlus4 + (immExt << SHIFT);

  // Sign-based tests avoid signed/unsigned mixing in the comparisons.
  always_comb begin
    condTaken = 1'b0;
    case (brOp_t'(bus.br_op))
      BR_BEQ:    condTaken = (bus.rs_val == bus.rt_val);
      BR_BNE:    condTaken = (bus.rs_val != bus.rt_val);
      BR_BLEZ:   condTaken = bus.rs_val[DW-1] || (bus.rs_val == '0);
      BR_BGTZ:   condTaken = !bus.rs_val[DW-1] && (bus.rs_val != '0);
      BR_BLTZ:   condTaken = bus.rs_val[DW-1];
      BR_BGEZ:   condTaken = !bus.rs_val[DW-1];
      BR_ALWAYS: condTaken = 1'b1;
      default:   condTaken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid   <= 1'b0;
      s1Taken   <= 1'b0;
      s1Pred    <= 1'b0;
      s1PcPlus4 <= '0;
      s1Target  <= '0;
      s1Idx     <= '0;
      s2Valid   <= 1'b0;
      s2Taken   <= 1'b0;
      s2Mis     <= 1'b0;
      s2Target  <= '0;
      s2NextPc  <= '0;
      s2Idx     <= '0;
    end else if (flush) begin
      s1Valid <= 1'b0;
      s2Valid <= 1'b0;
    end else begin
      if (s2Adv) begin
        s2Valid <= s1Valid;
        if (s1Valid) begin
          s2Taken  <= s1Taken;
          s2Target <= s1Target;
          s2NextPc <= s1Taken ? s1Target : s1PcPlus4;
          s2Mis    <= (s1Taken != s1Pred);
          s2Idx    <= s1Idx;
        end
      end
      if (s1Adv) begin
        s1Valid <= accept;
        if (accept) begin
          s1Taken   <= condTaken;
          s1Pred    <= bus.pred_taken;
          s1PcPlus4 <= pcPlus4;
          s1Target  <= brTarget;
          s1Idx     <= bus.pc[SHIFT +: IW];
        end
      end
    end
  end

  assign bus.out_valid  = s2Valid;
  assign bus.taken      = s2Taken;
  assign bus.target     = s2Target;
  assign bus.next_pc    = s2NextPc;
  assign bus.mispredict = s2Mis;

  assign unusedLookupBits = ^lookup_pc;

  // Flush wins over a same-cycle output handshake, so no training then.
  branch_pht #(
    .DEPTH (PHT_DEPTH),
    .IW    (IW)
  ) u_pht (
    .clk      (clk),
    .rst      (rst),
    .rdIdx    (lookup_pc[SHIFT +: IW]),
    .rdTaken  (lookup_taken),
    .updEn    (s2Valid && bus.out_ready && !flush),
    .updIdx   (s2Idx),
    .updTaken (s2Taken)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed plan cases plus randomized traffic vs a behavioural model.
module tb_branch_resolve_unit;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [31:0] nextPc;
    logic        mis;
    int          idx;
    int          acc;
    bit          chkLat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        lookup_taken;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit randDone = 1'b0;

  exp_t expQ[$];
  int   pht[16];

  branch_resolve_unit_if #(.AW(32), .DW(32), .IMM_W(16)) bus ();

  branch_resolve_unit #(
    .AW(32), .DW(32), .IMM_W(16), .SHIFT(2), .PHT_DEPTH(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .flush        (flush),
    .lookup_pc    (lookup_pc),
    .lookup_taken (lookup_taken)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference behaviour straight from the branch rules.
  function automatic exp_t model(input logic [31:0] pc, input logic [15:0] imm, input logic [2:0] op,
                                 input logic [31:0] rs, input logic [31:0] rt, input logic pred);
    exp_t e;
    longint t;
    int immS, rsS;
    logic [31:0] p4;
    immS = $signed(imm);
    rsS  = $signed(rs);
    t = longint'(pc) + 64'd4 + longint'(immS) * 4;
    e.target = t[31:0];
    p4 = pc + 32'd4;
    case (op)
      3'd0: e.taken = (rs == rt);
      3'd1: e.taken = (rs != rt);
      3'd2: e.taken = (rsS <= 0);
      3'd3: e.taken = (rsS > 0);
      3'd4: e.taken = (rsS < 0);
      3'd5: e.taken = (rsS >= 0);
      3'd6: e.taken = 1'b1;
      default: e.taken = 1'b0;
    endcase
    e.nextPc = e.taken ? e.target : p4;
    e.mis    = (e.taken != pred);
    e.idx    = int'(pc[5:2]);
    e.acc    = 0;
    e.chkLat = 1'b0;
    return e;
  endfunction

  function automatic exp_t mkExp(input logic tk, input logic [31:0] tg, input logic [31:0] nx,
                                 input logic mis, input logic [31:0] pc, input bit lat);
    exp_t e;
    e.taken = tk; e.target = tg; e.nextPc = nx; e.mis = mis;
    e.idx = int'(pc[5:2]); e.acc = 0; e.chkLat = lat;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Present one request; push its expectation at the cycle it is accepted.
  task automatic sendReq(input logic [31:0] pc, input logic [15:0] imm, input logic [2:0] op,
                         input logic [31:0] rs, input logic [31:0] rt, input logic pred, input exp_t e);
    bit done;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.pc = pc; bus.imm = imm; bus.br_op = op;
    bus.rs_val = rs; bus.rt_val = rt; bus.pred_taken = pred;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready && !rst) begin
        e.acc = cyc;
        expQ.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: got no in_ready, expected accept within 500 cycles");
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    bus.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic sendModel(input logic [31:0] pc, input logic [15:0] imm, input logic [2:0] op,
                           input logic [31:0] rs, input logic [31:0] rt, input logic pred);
    sendReq(pc, imm, op, rs, rt, pred, model(pc, imm, op, rs, rt, pred));
  endtask

  // Monitor: lookup check, hold-stability check and scoreboard pop.
  initial begin
    exp_t e;
    logic        held;
    logic [31:0] hTarget, hNext;
    logic        hTaken, hMis;
    logic [31:0] lpc;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        expQ.delete();
        for (int i = 0; i < 16; i++) pht[i] = 1;
        held = 1'b0;
      end else begin
        lpc = lookup_pc;
        chk("lookup_taken", 32'(lookup_taken), 32'(pht[int'(lpc[5:2])] >= 2));
        if (held && bus.out_valid) begin
          vectors++;
          if (bus.taken !== hTaken || bus.target !== hTarget || bus.next_pc !== hNext || bus.mispredict !== hMis) begin
            miscompares++;
            $display("FAIL hold_stable: got t=%0b tg=%0h np=%0h m=%0b, expected t=%0b tg=%0h np=%0h m=%0b",
                     bus.taken, bus.target, bus.next_pc, bus.mispredict, hTaken, hTarget, hNext, hMis);
          end
        end
        held = 1'b0;
        if (flush) begin
          expQ.delete();
        end else if (bus.out_valid && bus.out_ready) begin
          if (expQ.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_output: got out_valid=1 target=%0h, expected no output", bus.target);
          end else begin
            e = expQ.pop_front();
            vectors++;
            if (bus.taken !== e.taken || bus.target !== e.target || bus.next_pc !== e.nextPc || bus.mispredict !== e.mis) begin
              miscompares++;
              $display("FAIL result: got t=%0b tg=%0h np=%0h m=%0b, expected t=%0b tg=%0h np=%0h m=%0b",
                       bus.taken, bus.target, bus.next_pc, bus.mispredict, e.taken, e.target, e.nextPc, e.mis);
            end
            if (e.chkLat) chk("latency", 32'(cyc - e.acc), 32'd2);
            if (e.taken) pht[e.idx] = (pht[e.idx] == 3) ? 3 : pht[e.idx] + 1;
            else         pht[e.idx] = (pht[e.idx] == 0) ? 0 : pht[e.idx] - 1;
          end
        end else if (bus.out_valid) begin
          held = 1'b1;
          hTaken = bus.taken; hTarget = bus.target; hNext = bus.next_pc; hMis = bus.mispredict;
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.pc = '0; bus.imm = '0; bus.br_op = '0;
    bus.rs_val = '0; bus.rt_val = '0; bus.pred_taken = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_taken", 32'(bus.taken), 32'd0);
    chk("rst_mispredict", 32'(bus.mispredict), 32'd0);
    chk("rst_target", bus.target, 32'd0);
    chk("rst_next_pc", bus.next_pc, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_lookup", 32'(lookup_taken), 32'd0);

    // Directed cases with hand-derived results
    sendReq(32'd10, 16'd10, 3'd0, 32'd5, 32'd5, 1'b1, mkExp(1'b1, 32'd54, 32'd54, 1'b0, 32'd10, 1'b1));
    sendReq(32'd10, 16'd10, 3'd1, 32'd5, 32'd5, 1'b1, mkExp(1'b0, 32'd54, 32'd14, 1'b1, 32'd10, 1'b1));
    sendReq(32'd0, 16'hFFFF, 3'd0, 32'd1, 32'd2, 1'b0, mkExp(1'b0, 32'd0, 32'd4, 1'b0, 32'd0, 1'b1));
    sendReq(32'hFFFFFFFC, 16'd0, 3'd2, 32'hFFFFFFFF, 32'd0, 1'b0,
            mkExp(1'b1, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFC, 1'b1));
    sendReq(32'h100, 16'd0, 3'd7, 32'd3, 32'd3, 1'b1, mkExp(1'b0, 32'h104, 32'h104, 1'b1, 32'h100, 1'b1));
    sendReq(32'h100, 16'hFFFE, 3'd6, 32'd0, 32'd0, 1'b1, mkExp(1'b1, 32'hFC, 32'hFC, 1'b0, 32'h100, 1'b1));
    idle();
    repeat (4) @(posedge clk);

    // Backpressure: 4 ALWAYS branches with out_ready low
    #1 bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) sendModel(32'(i * 4), 16'd1, 3'd6, 32'd0, 32'd0, 1'b1);
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 bus.out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    chk("stall_drained", 32'(expQ.size()), 32'd0);

    // Predictor training at 0x40
    doReset();
    #1 lookup_pc = 32'h40;
    chk("pht_init", 32'(lookup_taken), 32'd0);
    sendModel(32'h40, 16'd0, 3'd6, 32'd0, 32'd0, 1'b1);
    idle(); repeat (2) @(posedge clk); #1;
    chk("pht_after_first", 32'(lookup_taken), 32'd1);
    sendModel(32'h40, 16'd0, 3'd6, 32'd0, 32'd0, 1'b1);
    sendModel(32'h40, 16'd0, 3'd6, 32'd0, 32'd0, 1'b1);
    idle(); repeat (3) @(posedge clk);
    sendModel(32'h40, 16'd0, 3'd1, 32'd7, 32'd7, 1'b1);
    idle(); repeat (2) @(posedge clk); #1;
    chk("pht_sat_dec1", 32'(lookup_taken), 32'd1);
    sendModel(32'h40, 16'd0, 3'd1, 32'd7, 32'd7, 1'b1);
    idle(); repeat (2) @(posedge clk); #1;
    chk("pht_dec2", 32'(lookup_taken), 32'd0);
    sendModel(32'h40, 16'd0, 3'd6, 32'd0, 32'd0, 1'b1);
    sendModel(32'h40, 16'd0, 3'd6, 32'd0, 32'd0, 1'b1);
    idle(); repeat (3) @(posedge clk); #1;
    chk("pht_retrained", 32'(lookup_taken), 32'd1);

    // Asynchronous reset mid-stream
    sendModel(32'h200, 16'd3, 3'd6, 32'd0, 32'd0, 1'b0);
    sendModel(32'h204, 16'd3, 3'd6, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_lookup", 32'(lookup_taken), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;

    // Flush with both stages full and a same-cycle handshake
    lookup_pc = 32'h80;
    bus.out_ready = 1'b0;
    sendModel(32'h80, 16'd0, 3'd6, 32'd0, 32'd0, 1'b1);
    sendModel(32'h84, 16'd0, 3'd6, 32'd0, 32'd0, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.pc = 32'h80; bus.br_op = 3'd6;
    flush = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_no_out", 32'(bus.out_valid), 32'd0);
    chk("flush_pht", 32'(lookup_taken), 32'd0);
    sendReq(32'h300, 16'd2, 3'd5, 32'd0, 32'd0, 1'b0, mkExp(1'b1, 32'h30C, 32'h30C, 1'b1, 32'h300, 1'b1));
    idle(); repeat (4) @(posedge clk);

    // Randomized traffic with random backpressure, flushes and lookups
    fork
      begin
        while (!randDone) begin
          @(posedge clk); #1;
          if (!randDone) bus.out_ready = ($urandom % 4) != 0;
        end
      end
      begin
        logic [31:0] rs, rt, pick;
        for (int n = 0; n < 300; n++) begin
          pick = $urandom % 5;
          case (pick)
            0: rs = 32'd0;
            1: rs = 32'hFFFFFFFF;
            2: rs = 32'h80000000;
            3: rs = 32'd1;
            default: rs = $urandom;
          endcase
          rt = ($urandom % 2) ? rs : $urandom;
          lookup_pc = $urandom;
          sendModel($urandom, 16'($urandom), 3'($urandom % 8), rs, rt, 1'($urandom % 2));
          if ($urandom % 4 == 0) idle();
          if ($urandom % 25 == 0) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0; flush = 1'b1;
            @(posedge clk); #1 flush = 1'b0;
          end
        end
        idle();
        randDone = 1'b1;
      end
    join
    @(posedge clk); #1 bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(posedge clk);
    chk("final_drain", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch-resolution stage for the MIPS execution path. It computes the branch target as `pc + 4 + (sext(imm) << SHIFT)` and evaluates the branch condition. It resolves taken/not-taken, flags mispredictions against the fetch-stage guess, and trains a table of 2-bit saturating predictors. It sits between decode/register-read and the PC-select logic and has a 2-stage valid/ready pipeline with flush.

## Interface
Parameters:
- AW, 32, address/PC width
- DW, 32, operand width
- IMM_W, 16, immediate width, sign-extended to AW
- SHIFT, 2, left shift applied to the immediate
- PHT_DEPTH, 16, predictor entries, power of two ≥ 2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  branch request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- pc  in  AW  branch instruction address
- imm  in  IMM_W  branch offset (signed)
- rs_val, rt_val  in  DW  operands
- br_op  in  3  condition code (see package)
- pred_taken  in  1  fetch-stage prediction for this branch
- flush  in  1  discard all in-flight branches
- out_valid  out  1  resolved result valid
- out_ready  in  1  consumer ready
- taken  out  1  resolved direction
- target  out  AW  computed target (always driven, even if not taken)
- next_pc  out  AW  taken ? target : pc+4
- mispredict  out  1  taken != pred_taken
- lookup_pc  in  AW  fetch-side predictor lookup address
- lookup_taken  out  1  MSB of indexed counter, combinational

## Operation
- Stage 1, on input accept:
  - register pc+4 and target, both computed mod 2^AW with wrap-around and no overflow flag.
  - evaluate the condition and register taken, pred_taken and the PHT index.
- Conditions:
  - BEQ: rs==rt
  - BNE: rs!=rt
  - BLEZ: rs≤0, signed
  - BGTZ: rs>0
  - BLTZ: rs<0
  - BGEZ: rs≥0
  - ALWAYS: taken
  - code 7 is reserved and resolves not-taken.
- Stage 2 is the output register holding taken, target, next_pc and mispredict.
- PHT index is pc[SHIFT +: log2(PHT_DEPTH)]. The same index function applies to lookup_pc.
- PHT update happens on output handshake (out_valid && out_ready):
  - taken → increment, saturate at 11.
  - not-taken → decrement, saturate at 00.
- Lookup of an entry being updated in the same cycle returns the pre-update value.
- flush clears the stage-1 and stage-2 valid bits on the next edge. Flushed entries never update the PHT and never appear at the output.
- in_ready is low while flush is high. A request presented during flush is not accepted.
- flush wins over a simultaneous output handshake: no PHT update occurs that cycle.

## Timing
- Latency is 2 cycles: a request accepted at edge N gives out_valid at edge N+2.
- Throughput is 1 branch/cycle when out_ready is held high.
- Stage advance rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv && !flush
- While out_valid && !out_ready, all output fields hold stable. Up to 2 requests are buffered, then in_ready falls.
- Reset values:
  - out_valid, taken, mispredict = 0
  - target, next_pc = 0
  - both stage valids = 0
  - every PHT entry = 01 (weakly not-taken), so lookup_taken = 0
  - in_ready = 1 after reset deasserts
- Reset asserted mid-operation clears everything immediately and asynchronously. In-flight branches are lost.

## Structure
- Package branch_pkg holds:
  - BR_BEQ..BR_ALWAYS codes: 0..6, with 7 reserved.
  - Counter constants: CNT_SNT=00, CNT_WNT=01, CNT_WT=10, CNT_ST=11.
  - PHT_RESET=CNT_WNT.
- Sub-module branch_pht holds the counter array, the combinational read port and one synchronous update port.
- Top level branch_resolve_unit holds the adder, comparator, pipeline registers and handshake.

## Test plan
- pc=10, imm=10, BEQ, rs=rt=5, pred_taken=1 → 2 cycles later: taken=1, target=54, next_pc=54, mispredict=0.
- pc=10, imm=10, BNE, rs=rt=5, pred_taken=1 → taken=0, target=54, next_pc=14, mispredict=1.
- Wrap and sign-extension:
  - pc=0, imm=0xFFFF → target=0.
  - pc=0xFFFFFFFC, imm=0, BLEZ rs=0xFFFFFFFF → taken=1, next_pc=0.
- Stream 4 ALWAYS branches at pc=0,4,8,12 with out_ready low for cycles 2–4 → in_ready drops after 2 pending, outputs held stable, all 4 emerge in order with no loss.
- Predictor training:
  - three accepted taken branches at pc=0x40 → lookup_pc=0x40 counter goes 01→10→11→11; lookup_taken=1 after the first update.
  - assert rst mid-stream → out_valid=0 immediately and lookup_taken=0.
- Both stages valid, assert flush for 1 cycle → no out_valid, PHT unchanged, in_ready=0 during flush; next request emerges normally 2 cycles after accept.
